keypad_encoder: RTL and testbench
=================================

# keypad_encoder

Time-entry front end for the countdown timer. Scans a 10-key (0–9) decimal keypad, synchronises and debounces it, and encodes each accepted press into a 4-bit BCD code. Accepted digits shift right-to-left into the `min`/`dSec`/`sec` digit registers, which feed the timer and the 7-segment display decoder. It is the encoding end of the BCD digit path that the display decoder consumes.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required before a press or release is recognised; legal range ≥2.
- `clk` in 1: single system clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `keypad` in 10: raw key lines, bit i = key i, active-high, asynchronous to `clk`.
- `entryEn` in 1: when high, accepted digits shift into the digit registers; when low, digits hold.
- `min` out 4: BCD minutes digit.
- `dSec` out 4: BCD tens-of-seconds digit, always 0–5.
- `sec` out 4: BCD seconds digit.
- `keyCode` out 4: BCD code of the last accepted key.
- `keyValid` out 1: one-cycle pulse per accepted press.
- `rejected` out 1: one-cycle pulse when a press is accepted but its shift is refused.
- `clear` in 1: present only with `KEYPAD_CLEAR_EN`; see Configuration.

## Operation
- Synchroniser: `keypad` passes through a 2-flop synchroniser. Encoding uses only the synchronised value.
- Encoding: exactly one bit set → code = bit index, valid. Zero bits or more than one bit → no key.
- FSM states:
  - IDLE: no key recognised.
    - Valid code seen → DEB_PRESS, counter = 1.
  - DEB_PRESS: debouncing a press.
    - Code changes, including to another valid key → counter reloads to 1; a no-key code returns to IDLE.
    - Counter reaches `DEBOUNCE_CYCLES` → accept the press, go to HELD.
  - HELD: key down, already accepted.
    - Any sample other than the held code → DEB_RELEASE, counter = 1.
  - DEB_RELEASE: debouncing a release.
    - No-key code for `DEBOUNCE_CYCLES` consecutive samples → IDLE.
    - Held code reappears → HELD.
    - A different valid code → HELD; the new key is not accepted. Only one press is accepted per full release.
- Accept action:
  - `keyCode` ← code and `keyValid` pulses, both regardless of `entryEn`.
  - If `entryEn`=1 and the current `sec` ≤ 5, shift: `min`←`dSec`, `dSec`←`sec`, `sec`←code. The old `min` is discarded.
  - If `entryEn`=1 and `sec` > 5, no shift occurs and `rejected` pulses in the same cycle as `keyValid`. This keeps `dSec` ≤ 5 at all times.
  - If `entryEn`=0, there is no shift and no `rejected`.
- Arithmetic: counter width is $clog2(DEBOUNCE_CYCLES+1). The counter saturates; there is no wrap.

## Timing
- Reset (`rst_n` low at an edge): `min`/`dSec`/`sec`/`keyCode` = 0, `keyValid`/`rejected` = 0, synchroniser flops = 0, FSM = IDLE, counter = 0.
- Reset asserted mid-debounce or mid-hold aborts the operation with no pulse. A key held through reset is accepted once after a full debounce.
- Press latency: `keypad` becomes a stable single key before edge k → `keyValid` is high during the cycle after edge k+1+`DEBOUNCE_CYCLES`. Digit registers update at that same edge.
- `keyValid` and `rejected` are registered and last exactly one cycle.
- `entryEn` is sampled in the accept cycle only.
- Minimum press-to-press interval: 2×`DEBOUNCE_CYCLES` + 2 cycles.

## Configuration
- `KEYPAD_CLEAR_EN` defined:
  - Adds port `clear` (in, 1, active-high, synchronous).
  - When high at an edge, `min`/`dSec`/`sec` ← 0. The FSM and `keyCode` are unaffected.
  - If an accept coincides with `clear`, `clear` wins: digits go to 0, `keyValid` still pulses, and `rejected` does not pulse.
- `KEYPAD_CLEAR_EN` undefined: no `clear` port. Digits are cleared only by reset.

## Structure
- Shared package `timer_pkg`:
  - `bcd_t` (logic [3:0]).
  - FSM state enum `keypad_state_t` (IDLE, DEB_PRESS, HELD, DEB_RELEASE).
  - Constant `NO_KEY`.
  - Constant `MAX_DSEC` = 5.
- Sub-module `key_debouncer`:
  - Contains the synchroniser, one-hot encoder, FSM and counter.
  - Outputs an accept pulse plus the code.
- Top level holds the digit shift registers, the `sec` ≤ 5 check and the clear logic.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.

- Reset then idle → all outputs 0 for 20 cycles.
- Clean press and release of key 7, `entryEn`=1 → one `keyValid` 6 cycles after the pin change; `keyCode`=7; `sec`=7, `dSec`=0, `min`=0.
- Presses 1, 3, 0 with full releases between → `min`=1, `dSec`=3, `sec`=0. A following press of 9 → `min`=3, `dSec`=0, `sec`=9.
- With `sec`=9, press 2 → `keyValid` and `rejected` pulse in the same cycle; digits unchanged.
- Bounce: key 4 toggling every 2 cycles for 12 cycles, then stable → exactly one `keyValid`. Release bounce and two keys held together → no `keyValid`.
- `rst_n` low at the 2nd debounce cycle → no pulse. `clear` (with `KEYPAD_CLEAR_EN`) coinciding with an accept of 5 → digits 0, `keyValid`=1, `rejected`=0.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared types and constants for the countdown-timer BCD digit path.
//   bcd_t           4-bit BCD digit
//   keypad_state_t  key debouncer FSM states
//   NO_KEY          code reported when zero or several keys are down
//   MAX_DSEC        largest legal tens-of-seconds digit
//   encode_key()    one-hot keypad lines to BCD code, NO_KEY otherwise
package timer_pkg;
  typedef logic [3:0] bcd_t;
  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} keypad_state_t;
  localparam bcd_t NO_KEY = 4'hF;
  localparam bcd_t MAX_DSEC = 4'd5;
  function automatic bcd_t encode_key(input logic [9:0] keys);
    encode_key = NO_KEY;
    if ($onehot(keys))
      for (int i = 0; i < 10; i++)
        if (keys[i]) encode_key = bcd_t'(i);
  endfunction
endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: synchronises, encodes and debounces the 10-key keypad.
//   clk, rst_n  system clock, synchronous active-low reset
//   i_keypad    raw asynchronous key lines, bit i = key i
//   o_accept    combinational, high in the cycle whose edge accepts a press
//   o_code      BCD code of the key being debounced/held
module key_debouncer
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] i_keypad,
  output logic       o_accept,
  output bcd_t       o_code
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [9:0] r_sync1, r_sync2;
  keypad_state_t r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_nx, w_inc;
  bcd_t r_held, w_held_nx, w_code;
  logic w_valid, w_done;
  assign w_code = encode_key(r_sync2);
  assign w_valid = w_code != NO_KEY;
  // Saturating increment: w_done means this sample completes the stable run.
  assign w_inc = (r_cnt == CW'(DEBOUNCE_CYCLES)) ? r_cnt : r_cnt + 1'b1;
  assign w_done = w_inc == CW'(DEBOUNCE_CYCLES);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_state <= IDLE;
      r_cnt <= '0;
      r_held <= NO_KEY;
    end else begin
      r_sync1 <= i_keypad;
      r_sync2 <= r_sync1;
      r_state <= w_next;
      r_cnt <= w_cnt_nx;
      r_held <= w_held_nx;
    end
  end
  // r_held is the candidate code while debouncing a press and the
  // accepted code while held; a different key during release never re-arms.
  always_comb begin
    w_next = r_state;
    w_cnt_nx = r_cnt;
    w_held_nx = r_held;
    case (r_state)
      IDLE:
        if (w_valid) begin
          w_next = DEB_PRESS;
          w_cnt_nx = CW'(1);
          w_held_nx = w_code;
        end
      DEB_PRESS:
        if (!w_valid) begin
          w_next = IDLE;
          w_cnt_nx = '0;
        end else if (w_code != r_held) begin
          w_cnt_nx = CW'(1);
          w_held_nx = w_code;
        end else begin
          w_cnt_nx = w_inc;
          if (w_done) w_next = HELD;
        end
      HELD:
        if (w_code != r_held) begin
          w_next = DEB_RELEASE;
          w_cnt_nx = CW'(1);
        end
      DEB_RELEASE:
        if (w_valid) w_next = HELD;
        else if (w_done) begin
          w_next = IDLE;
          w_cnt_nx = '0;
        end else w_cnt_nx = w_inc;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    o_accept = r_state == DEB_PRESS && w_code == r_held && w_done;
    o_code = r_held;
  end
endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder: keypad time-entry front end shifting BCD digits into min/dSec/sec.
//   clk, rst_n      system clock, synchronous active-low reset
//   keypad          raw key lines 0-9, active-high, asynchronous
//   entryEn         allow accepted digits to shift into the digit registers
//   clear           (KEYPAD_CLEAR_EN only) synchronous clear of min/dSec/sec
//   min, dSec, sec  BCD digit registers, dSec always 0-5
//   keyCode         code of the last accepted key
//   keyValid        one-cycle pulse per accepted press
//   rejected        one-cycle pulse when an accepted digit cannot shift
// Optional feature macro: KEYPAD_CLEAR_EN.
module keypad_encoder
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] keypad,
  input  logic       entryEn,
`ifdef KEYPAD_CLEAR_EN
  input  logic       clear,
`endif
  output bcd_t       min,
  output bcd_t       dSec,
  output bcd_t       sec,
  output bcd_t       keyCode,
  output logic       keyValid,
  output logic       rejected
);
  logic w_accept, w_clear, w_shift, w_reject;
  bcd_t w_code;
`ifdef KEYPAD_CLEAR_EN
  assign w_clear = clear;
`else
  assign w_clear = 1'b0;
`endif
  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk),
    .rst_n(rst_n),
    .i_keypad(keypad),
    .o_accept(w_accept),
    .o_code(w_code)
  );
  // sec moves into dSec, so it may only shift when sec is a legal tens digit.
  assign w_shift = w_accept && entryEn && sec <= MAX_DSEC;
  assign w_reject = w_accept && entryEn && sec > MAX_DSEC && !w_clear;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min <= '0;
      dSec <= '0;
      sec <= '0;
      keyCode <= '0;
      keyValid <= 1'b0;
      rejected <= 1'b0;
    end else begin
      keyValid <= w_accept;
      rejected <= w_reject;
      if (w_accept) keyCode <= w_code;
      if (w_clear) begin
        min <= '0;
        dSec <= '0;
        sec <= '0;
      end else if (w_shift) begin
        min <= dSec;
        dSec <= sec;
        sec <= w_code;
      end
    end
  end
endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: directed self-checking bench for keypad_encoder with DEBOUNCE_CYCLES=4.
module tb_keypad_encoder;
  import timer_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [9:0] keypad = '0;
  logic entryEn = 1'b0;
  logic clear = 1'b0;
  bcd_t min, dSec, sec, keyCode;
  logic keyValid, rejected;
  int n_chk = 0, n_fail = 0;
  int kv_cnt = 0, rej_cnt = 0, both_cnt = 0;
  int kv0, rj0, b0;
  keypad_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .keypad(keypad),
    .entryEn(entryEn),
`ifdef KEYPAD_CLEAR_EN
    .clear(clear),
`endif
    .min(min),
    .dSec(dSec),
    .sec(sec),
    .keyCode(keyCode),
    .keyValid(keyValid),
    .rejected(rejected)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst_n) begin
      kv_cnt += int'(keyValid);
      rej_cnt += int'(rejected);
      both_cnt += int'(keyValid & rejected);
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    keypad = '0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask
  task automatic press(input int k);
    keypad = 10'd1 << k;
    step(8);
    keypad = '0;
    step(8);
  endtask
  initial begin
    do_reset();
    for (int i = 0; i < 20; i++) begin
      chk("reset_idle", int'({min, dSec, sec, keyCode, keyValid, rejected}), 0);
      step(1);
    end
    entryEn = 1'b1;
    kv0 = kv_cnt;
    keypad = 10'd1 << 7;
    step(5);
    chk("lat_early", int'(keyValid), 0);
    step(1);
    chk("lat_pulse", int'(keyValid), 1);
    chk("lat_code", int'(keyCode), 7);
    chk("lat_digits", int'({min, dSec, sec}), 'h007);
    chk("lat_rej", int'(rejected), 0);
    step(1);
    chk("pulse_width", int'(keyValid), 0);
    keypad = '0;
    step(10);
    chk("one_press", kv_cnt - kv0, 1);
    do_reset();
    kv0 = kv_cnt;
    press(1);
    press(3);
    press(0);
    chk("seq_130", int'({min, dSec, sec}), 'h130);
    chk("seq_cnt", kv_cnt - kv0, 3);
    press(9);
    chk("seq_309", int'({min, dSec, sec}), 'h309);
    b0 = both_cnt;
    press(2);
    chk("rej_both", both_cnt - b0, 1);
    chk("rej_digits", int'({min, dSec, sec}), 'h309);
    chk("rej_code", int'(keyCode), 2);
    entryEn = 1'b0;
    rj0 = rej_cnt;
    kv0 = kv_cnt;
    press(4);
    chk("dis_kv", kv_cnt - kv0, 1);
    chk("dis_code", int'(keyCode), 4);
    chk("dis_digits", int'({min, dSec, sec}), 'h309);
    chk("dis_norej", rej_cnt - rj0, 0);
    do_reset();
    entryEn = 1'b1;
    kv0 = kv_cnt;
    for (int i = 0; i < 6; i++) begin
      keypad = (i % 2 == 0) ? 10'd1 << 4 : 10'd0;
      step(2);
    end
    chk("bounce_none", kv_cnt - kv0, 0);
    keypad = 10'd1 << 4;
    step(8);
    chk("bounce_one", kv_cnt - kv0, 1);
    chk("bounce_digits", int'({min, dSec, sec}), 'h004);
    for (int i = 0; i < 6; i++) begin
      keypad = (i % 2 == 0) ? 10'd0 : 10'd1 << 4;
      step(2);
    end
    keypad = '0;
    step(8);
    chk("rel_bounce", kv_cnt - kv0, 1);
    keypad = 10'b0000000110;
    step(12);
    keypad = '0;
    step(8);
    chk("two_keys", kv_cnt - kv0, 1);
    keypad = 10'd1 << 5;
    step(8);
    chk("key5", kv_cnt - kv0, 2);
    keypad = 10'd1 << 6;
    step(12);
    chk("rollover_none", kv_cnt - kv0, 2);
    chk("rollover_code", int'(keyCode), 5);
    chk("rollover_digits", int'({min, dSec, sec}), 'h045);
    keypad = '0;
    step(8);
    do_reset();
    kv0 = kv_cnt;
    keypad = 10'd1 << 3;
    step(3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("rst_abort_kv", int'(keyValid), 0);
    chk("rst_abort_cnt", kv_cnt - kv0, 0);
    step(12);
    chk("rst_held_once", kv_cnt - kv0, 1);
    chk("rst_held_code", int'(keyCode), 3);
    keypad = '0;
    step(8);
    press(9);
    chk("pre_clear", int'({min, dSec, sec}), 'h039);
    keypad = 10'd1 << 5;
    step(5);
`ifdef KEYPAD_CLEAR_EN
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_kv", int'(keyValid), 1);
    chk("clr_rej", int'(rejected), 0);
    chk("clr_digits", int'({min, dSec, sec}), 0);
    chk("clr_code", int'(keyCode), 5);
`else
    step(1);
    chk("sec9_kv", int'(keyValid), 1);
    chk("sec9_rej", int'(rejected), 1);
    chk("sec9_digits", int'({min, dSec, sec}), 'h039);
    chk("sec9_code", int'(keyCode), 5);
`endif
    keypad = '0;
    step(8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
